// File: rtl/ppu_vram_ctrl.sv
// ppu_vram_ctrl: arbitrates register-interface and render fetches onto CHR, CIRAM and palette with a fixed 2-clk read latency.
// Optional CHR_RAM_EN: register-interface writes to $0000-$1FFF reach pattern memory (CHR-RAM cartridge).
module ppu_vram_ctrl #(
    parameter int NT_AW  = 11,
    parameter int CHR_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mirror,
    input  logic [13:0]       ri_addr,
    input  logic [7:0]        ri_din,
    input  logic              ri_wr_req,
    input  logic              ri_rd_req,
    output logic [7:0]        ri_dout,
    output logic              ri_ack,
    output logic              ri_busy,
    input  logic [13:0]       rnd_addr,
    input  logic              rnd_rd_req,
    output logic [7:0]        rnd_dout,
    output logic              rnd_valid,
    output logic [CHR_AW-1:0] chr_addr,
    input  logic [7:0]        chr_din,
    output logic [7:0]        chr_dout,
    output logic              chr_we,
    output logic [NT_AW-1:0]  nt_addr,
    input  logic [7:0]        nt_din,
    output logic [7:0]        nt_dout,
    output logic              nt_we
);
    typedef enum logic [1:0] {IDLE, ISSUE_RND, ISSUE_RI} state_t;
    localparam logic [1:0] TGT_CHR = 2'd0, TGT_NT = 2'd1, TGT_PAL = 2'd2;

    state_t      st, st_nxt, cap;
    logic        pend_v, pend_w, new_ri, go_ri, cur_w, wr, page;
    logic [13:0] pend_a, a;
    logic [7:0]  pend_d, d, s1_pal, c_pal, rdata;
    logic [1:0]  tgt, s1_tgt, c_tgt;
    logic [4:0]  pidx;
    logic        s1_wr, c_wr;
    logic [5:0]  pal [32];

    always_comb begin
        new_ri = (ri_wr_req | ri_rd_req) & ~ri_busy;
        go_ri  = ~rnd_rd_req & (pend_v | new_ri);
        cur_w  = pend_v ? pend_w : ri_wr_req;
        a      = rnd_rd_req ? rnd_addr : pend_v ? pend_a : ri_addr;
        d      = pend_v ? pend_d : ri_din;
        tgt    = ~a[13] ? TGT_CHR : (a[13:8] == 6'h3F) ? TGT_PAL : TGT_NT;
        page   = mirror[1] ? mirror[0] : mirror[0] ? a[10] : a[11];
        // $3F10/14/18/1C fold onto the shared backdrop entries
        pidx   = {a[4] & (a[1:0] != 2'b00), a[3:0]};
        wr     = go_ri & cur_w;
        st_nxt = rnd_rd_req ? ISSUE_RND : go_ri ? ISSUE_RI : IDLE;
        rdata  = (c_tgt == TGT_PAL) ? c_pal : (c_tgt == TGT_NT) ? nt_din : chr_din;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else     st <= st_nxt;

    always_ff @(posedge clk)
        if (!rst && wr && tgt == TGT_PAL) pal[pidx] <= d[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v <= 1'b0; pend_w <= 1'b0; pend_a <= '0; pend_d <= '0;
            ri_busy <= 1'b0; ri_ack <= 1'b0; ri_dout <= '0;
            rnd_valid <= 1'b0; rnd_dout <= '0;
            chr_addr <= '0; nt_addr <= '0; nt_dout <= '0; nt_we <= 1'b0;
            s1_tgt <= TGT_CHR; s1_wr <= 1'b0; s1_pal <= '0;
            cap <= IDLE; c_tgt <= TGT_CHR; c_wr <= 1'b0; c_pal <= '0;
        end else begin
            pend_v <= (pend_v | new_ri) & ~go_ri;
            if (new_ri) begin
                pend_w <= ri_wr_req;
                pend_a <= ri_addr;
                pend_d <= ri_din;
            end
            ri_busy <= new_ri | (ri_busy & ~ri_ack);
            if (st_nxt != IDLE) begin
                chr_addr <= a[CHR_AW-1:0];
                nt_addr  <= NT_AW'({page, a[9:0]});
            end
            nt_we <= wr & (tgt == TGT_NT);
            if (wr) nt_dout <= d;
            s1_tgt <= tgt;
            s1_wr  <= wr;
            s1_pal <= {2'b00, pal[pidx]};
            cap    <= st;
            c_tgt  <= s1_tgt;
            c_wr   <= s1_wr;
            c_pal  <= s1_pal;
            rnd_valid <= cap == ISSUE_RND;
            if (cap == ISSUE_RND) rnd_dout <= rdata;
            ri_ack <= cap == ISSUE_RI;
            if (cap == ISSUE_RI && !c_wr) ri_dout <= rdata;
        end
    end

`ifdef CHR_RAM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chr_we   <= 1'b0;
            chr_dout <= '0;
        end else begin
            chr_we <= wr & (tgt == TGT_CHR);
            if (wr) chr_dout <= d;
        end
    end
`else
    assign chr_we   = 1'b0;
    assign chr_dout = '0;
`endif
endmodule

// File: doc/ppu_vram_ctrl.md
Name: ppu_vram_ctrl

Overview:
- Downstream of the PPU register interface. Consumes its single-cycle PPU memory read/write requests ($2007 path) and the rendering pipeline's fetch requests.
- Arbitrates between the two request sources.
- Decodes the 14-bit PPU address into the CHR pattern space, the nametable CIRAM (with mirroring) and the internal palette RAM.
- Returns read data with a fixed latency.

Parameters:
- NT_AW, 11, CIRAM address width (2 KB nametable RAM)
- CHR_AW, 13, CHR pattern memory address width (8 KB)

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  reset; asynchronous, active-high
- mirror  in  2  nametable mirroring: 00 horizontal, 01 vertical, 10 single-screen low, 11 single-screen high
- ri_addr  in  14  register-interface access address
- ri_din  in  8  register-interface write data
- ri_wr_req  in  1  one-clk write request pulse
- ri_rd_req  in  1  one-clk read request pulse
- ri_dout  out  8  register-interface read data
- ri_ack  out  1  one-clk pulse; read data valid or write committed
- ri_busy  out  1  register-interface request pending or in flight
- rnd_addr  in  14  render fetch address
- rnd_rd_req  in  1  render read request, sampled every clk
- rnd_dout  out  8  render read data
- rnd_valid  out  1  one-clk pulse, rnd_dout valid
- chr_addr  out  CHR_AW  pattern memory address
- chr_din  in  8  pattern memory read data (synchronous memory, 1-clk latency)
- chr_dout  out  8  pattern memory write data
- chr_we  out  1  pattern memory write enable
- nt_addr  out  NT_AW  CIRAM address
- nt_din  in  8  CIRAM read data (synchronous memory, 1-clk latency)
- nt_dout  out  8  CIRAM write data
- nt_we  out  1  CIRAM write enable

Behaviour:
- Reset: all outputs 0; pending request and pipeline cleared. Palette contents are not reset.
- Reset asserted mid-operation: in-flight access discarded; no ack or valid pulse; no write completes.
- Decode on address bits [13:0]:
  - $0000-$1FFF → CHR, chr_addr = a[12:0].
  - $2000-$3EFF → CIRAM.
  - $3F00-$3FFF → palette.
- CIRAM page bit:
  - horizontal: a[11]
  - vertical: a[10]
  - single-screen low: 0
  - single-screen high: 1
  - nt_addr = {page, a[9:0]}.
- Palette: 32x6 internal registers. Index = a[4:0], except when a[4]=1 and a[1:0]=00, where a[4] is cleared ($3F10/14/18/1C alias $3F00/04/08/0C). Reads return {2'b00, entry}; writes store din[5:0].
- RI pending latch: set by ri_wr_req or ri_rd_req while ri_busy=0, capturing address, data and direction. Pulses while ri_busy=1 are dropped. If wr and rd arrive together, the write wins.
- Arbitration, per clk:
  - rnd_rd_req high → render access issued.
  - Otherwise, if RI pending → RI access issued.
  - Render starves RI only while rnd_rd_req is held continuously.
- State machine:
  - IDLE → ISSUE_RND or ISSUE_RI.
  - ISSUE_x drives registered memory outputs → CAPTURE.
  - CAPTURE registers data and pulses ack or valid.
  - Pipelined: a new render request may issue every clk, back-to-back.
- Latency:
  - Request sampled at edge E0; memory address/enables registered at E0.
  - Memory data at E1; rnd_valid/rnd_dout (or ri_ack/ri_dout) registered at E2.
  - Fixed 2-clk latency for all targets, palette included.
- Writes:
  - chr_we/nt_we high for exactly one clk.
  - Palette updated at the issue edge.
  - ri_ack 2 clks after issue; ri_dout unchanged on writes.
- ri_busy falls in the clk after ri_ack.
- Render requests are never writes.

Optional Feature:
- CHR_RAM_EN defined: RI writes to $0000-$1FFF assert chr_we with chr_dout = data (CHR-RAM cartridge).
- CHR_RAM_EN undefined: chr_we tied 0, chr_dout tied 0. CHR writes are dropped but still acked (CHR-ROM).

Test Plan:
- mirror=01, RI write $2C05=0xA5; RI read $2405 → nt_we pulse with nt_addr=0x405; read ri_dout=0xA5; ri_ack 2 clks after issue each time.
- RI write $3F10=0xFF; render read $3F00 → rnd_dout=0x3F; read $3F11 independent of $3F01.
- rnd_rd_req held 4 clks, ri_rd_req pulsed at clk 1 → 4 rnd_valid pulses on consecutive clks; RI serviced on clk 4; ri_busy high throughout, low after ack.
- Second ri_wr_req during ri_busy → dropped; exactly one nt_we and one ri_ack.
- rst asserted 1 clk after RI write issue → no ri_ack; outputs 0 immediately.
- RI write $1234=0x5A: with CHR_RAM_EN, chr_we=1 and chr_addr=0x1234; without it, chr_we stays 0 and ri_ack still pulses.
